// File: rtl/fir_sequencer.sv
// fir_sequencer: autonomous run controller for the FIR engine.
//
// Acts as an AXI-Lite master that programs the FIR for one complete run:
// data length to 0x10, NUM_TAPS coefficients to 0x20 + 4*i, then ap_start
// (0x00 = 1). It then gates the sample stream, marks the last input sample,
// counts output beats, and polls 0x00 until ap_done (bit 1) is read back.
//
// Handshake rule (all channels): a transfer happens on a clock edge where
// valid and ready are both high; a valid, once raised, stays high with stable
// payload until that edge.
//
// Ports
//   axis_clk, axis_rst_n    clock, async active-low reset
//   start, data_len         run request; length is latched when accepted
//   busy, done              run in progress / one-cycle completion pulse
//   tap_valid/ready/data    coefficient source
//   aw*, w*                 AXI-Lite write address / data channels
//   ar*, r*                 AXI-Lite read address / data channels
//   stream_en, ss_tlast     sample gating and last-sample marker
//   ss_fire, sm_fire        observed input / output stream handshakes
//   dbg_state               current FSM state
module fir_sequencer #(
  parameter int NUM_TAPS = 11,
  parameter int ADDR_W   = 12,
  parameter int DATA_W   = 32
) (
  input  logic              axis_clk,
  input  logic              axis_rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data_len,
  output logic              busy,
  output logic              done,
  input  logic              tap_valid,
  output logic              tap_ready,
  input  logic [DATA_W-1:0] tap_data,
  output logic              awvalid,
  input  logic              awready,
  output logic [ADDR_W-1:0] awaddr,
  output logic              wvalid,
  input  logic              wready,
  output logic [DATA_W-1:0] wdata,
  output logic              arvalid,
  input  logic              arready,
  output logic [ADDR_W-1:0] araddr,
  input  logic              rvalid,
  output logic              rready,
  input  logic [DATA_W-1:0] rdata,
  output logic              stream_en,
  input  logic              ss_fire,
  input  logic              sm_fire,
  output logic              ss_tlast,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_LEN, S_WR_TAP, S_WR_START,
    S_STREAM, S_POLL_AR, S_POLL_R, S_DONE
  } state_t;

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   len_q, ss_cnt_q, sm_cnt_q;
  logic [TAP_W-1:0]    tap_idx_q;

  logic                chan_idle, wr_cmpl, launch;
  logic [ADDR_W-1:0]   launch_addr, tap_addr;
  logic [DATA_W-1:0]   launch_data;

  // Only ap_done is of interest in the status word.
  logic unused_rdata;
  assign unused_rdata = ^{rdata[DATA_W-1:2], rdata[0]};

  assign chan_idle = ~awvalid & ~wvalid;
  // Completes on the edge where the last outstanding channel is accepted;
  // the two channels may finish on different edges.
  assign wr_cmpl   = ~chan_idle & ~(awvalid & ~awready) & ~(wvalid & ~wready);
  assign tap_addr  = ADDR_W'(32'h20) + ADDR_W'({tap_idx_q, 2'b00});

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign arvalid   = (state_q == S_POLL_AR);
  assign araddr    = '0;
  assign rready    = (state_q == S_POLL_R);
  assign stream_en = (state_q == S_STREAM) && (ss_cnt_q < len_q);
  assign ss_tlast  = stream_en && (ss_cnt_q == len_q - DATA_W'(1));
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    launch      = 1'b0;
    launch_addr = '0;
    launch_data = '0;
    tap_ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start && (data_len != '0)) state_d = S_WR_LEN;
      end
      S_WR_LEN: begin
        // The channel stays busy until completion moves the state on,
        // so chan_idle alone prevents a second launch.
        launch      = chan_idle;
        launch_addr = ADDR_W'(32'h10);
        launch_data = len_q;
        if (wr_cmpl) state_d = S_WR_TAP;
      end
      S_WR_TAP: begin
        tap_ready   = tap_valid && chan_idle;
        launch      = tap_ready;
        launch_addr = tap_addr;
        launch_data = tap_data;
        if (wr_cmpl && (tap_idx_q == LAST_TAP)) state_d = S_WR_START;
      end
      S_WR_START: begin
        launch      = chan_idle;
        launch_addr = '0;
        launch_data = DATA_W'(1);
        if (wr_cmpl) state_d = S_STREAM;
      end
      S_STREAM: begin
        if (sm_cnt_q == len_q) state_d = S_POLL_AR;
      end
      S_POLL_AR: begin
        if (arready) state_d = S_POLL_R;
      end
      S_POLL_R: begin
        if (rvalid) state_d = rdata[1] ? S_DONE : S_POLL_AR;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= S_IDLE;
      len_q     <= '0;
      ss_cnt_q  <= '0;
      sm_cnt_q  <= '0;
      tap_idx_q <= '0;
      awvalid   <= 1'b0;
      wvalid    <= 1'b0;
      awaddr    <= '0;
      wdata     <= '0;
    end else begin
      state_q <= state_d;

      if (launch) begin
        awvalid <= 1'b1;
        wvalid  <= 1'b1;
        awaddr  <= launch_addr;
        wdata   <= launch_data;
      end else begin
        if (awvalid && awready) awvalid <= 1'b0;
        if (wvalid && wready)   wvalid  <= 1'b0;
      end

      if ((state_q == S_IDLE) && start && (data_len != '0)) begin
        len_q     <= data_len;
        ss_cnt_q  <= '0;
        sm_cnt_q  <= '0;
        tap_idx_q <= '0;
      end

      // Index advances after its write completes, except on the last tap.
      if ((state_q == S_WR_TAP) && wr_cmpl && (tap_idx_q != LAST_TAP))
        tap_idx_q <= tap_idx_q + TAP_W'(1);

      if (state_q == S_STREAM) begin
        if (stream_en && ss_fire)          ss_cnt_q <= ss_cnt_q + DATA_W'(1);
        if (sm_fire && (sm_cnt_q < len_q)) sm_cnt_q <= sm_cnt_q + DATA_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb_fir_sequencer: directed bench for fir_sequencer with an AXI-Lite slave,
// tap source and stream models; table of runs plus hand-written corner cases.
module tb_fir_sequencer;
  localparam int NUM_TAPS = 11;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;

  logic              axis_clk = 1'b0;
  logic              axis_rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] data_len = '0;
  logic              busy, done;
  logic              tap_valid = 1'b0;
  logic              tap_ready;
  logic [DATA_W-1:0] tap_data = '0;
  logic              awvalid;
  logic              awready = 1'b0;
  logic [ADDR_W-1:0] awaddr;
  logic              wvalid;
  logic              wready = 1'b0;
  logic [DATA_W-1:0] wdata;
  logic              arvalid;
  logic              arready = 1'b0;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid = 1'b0;
  logic              rready;
  logic [DATA_W-1:0] rdata = '0;
  logic              stream_en;
  logic              ss_fire = 1'b0;
  logic              sm_fire = 1'b0;
  logic              ss_tlast;
  logic [2:0]        dbg_state;

  fir_sequencer #(.NUM_TAPS(NUM_TAPS), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n), .start(start), .data_len(data_len),
    .busy(busy), .done(done), .tap_valid(tap_valid), .tap_ready(tap_ready),
    .tap_data(tap_data), .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .arvalid(arvalid),
    .arready(arready), .araddr(araddr), .rvalid(rvalid), .rready(rready),
    .rdata(rdata), .stream_en(stream_en), .ss_fire(ss_fire), .sm_fire(sm_fire),
    .ss_tlast(ss_tlast), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 axis_clk = ~axis_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bench state ----------------
  typedef struct {
    int len;
    int aw_delay;
    int w_delay;
    int zero_polls;
    bit tap_gap;
    bit start_mid;
    int exp_ar;
    int exp_split;
  } vec_t;

  vec_t vecs[4];

  int n_tests = 0;
  int n_fail  = 0;

  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W-1:0]        got_aw[$];
  logic [DATA_W-1:0]        got_w[$];

  int cyc = 0;
  int aw_hs, w_hs, ar_hs, r_hs, done_cnt, done_cyc, rdone_cyc;
  int ss_beats, sm_beats, tlast_cnt, tlast_idx, split_cnt, order_viol;
  int tap_ptr, gap_left, gap_viol, poll_idx;
  bit gap_en, gap_done, tap_on;
  int aw_delay, w_delay, zero_polls;
  int aw_age, w_age, aw_age_n, w_age_n;
  logic aw_prev = 1'b0, w_prev = 1'b0;
  logic [DATA_W-1:0] tap_base;

  // ---------------- monitor (pre-edge samples) ----------------
  always @(posedge axis_clk) begin
    cyc++;
    if ((awvalid && !aw_prev) != (wvalid && !w_prev)) order_viol++;
    if (awvalid && !aw_prev && (aw_hs != w_hs)) order_viol++;
    if (awvalid != wvalid) split_cnt++;
    if (gap_left > 0 && tap_ready) gap_viol++;
    if (awvalid && awready) begin got_aw.push_back(awaddr); aw_hs++; end
    if (wvalid && wready)   begin got_w.push_back(wdata);   w_hs++;  end
    if (arvalid && arready) ar_hs++;
    if (rvalid && rready) begin
      r_hs++;
      if (rdata[1]) rdone_cyc = cyc;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (ss_fire) begin
      if (ss_tlast) begin tlast_cnt++; tlast_idx = ss_beats; end
      ss_beats++;
    end
    if (sm_fire) sm_beats++;
    if (tap_valid && tap_ready) begin
      tap_ptr++;
      if (gap_en && tap_ptr == 4 && !gap_done) begin gap_left = 5; gap_done = 1'b1; end
    end else if (gap_left > 0) begin
      gap_left--;
    end
    aw_prev = awvalid;
    w_prev  = wvalid;
  end

  // ---------------- responders (drive at +1) ----------------
  always @(posedge axis_clk) begin
    aw_age_n = (awvalid && !awready) ? aw_age + 1 : 0;
    w_age_n  = (wvalid && !wready) ? w_age + 1 : 0;
    if (rvalid && rready) poll_idx++;
    #1;
    aw_age    = aw_age_n;
    w_age     = w_age_n;
    awready   = awvalid && (aw_age >= aw_delay);
    wready    = wvalid && (w_age >= w_delay);
    arready   = arvalid;
    rvalid    = rready;
    rdata     = (poll_idx < zero_polls) ? 32'h0 : 32'h2;
    ss_fire   = stream_en;
    sm_fire   = (sm_beats < ss_beats);
    tap_valid = tap_on && (tap_ptr < NUM_TAPS) && (gap_left == 0);
    tap_data  = tap_base + DATA_W'(tap_ptr);
  end

  // ---------------- driver / check tasks ----------------
  task automatic tick();
    @(posedge axis_clk);
    #2;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic clear_run(input int idx);
    exp_q.delete(); got_aw.delete(); got_w.delete();
    aw_hs = 0; w_hs = 0; ar_hs = 0; r_hs = 0; done_cnt = 0; done_cyc = 0; rdone_cyc = 0;
    ss_beats = 0; sm_beats = 0; tlast_cnt = 0; tlast_idx = -1; split_cnt = 0; order_viol = 0;
    tap_ptr = 0; gap_left = 0; gap_viol = 0; gap_done = 1'b0; poll_idx = 0;
    tap_base = 32'hA000_0000 + DATA_W'(idx) * 32'h100;
  endtask

  task automatic pulse_start(input logic [DATA_W-1:0] len);
    start = 1'b1; data_len = len;
    tick();
    start = 1'b0; data_len = '0;
  endtask

  task automatic run_case(input vec_t v, input int idx);
    bit pulsed = 1'b0;
    clear_run(idx);
    aw_delay = v.aw_delay; w_delay = v.w_delay; zero_polls = v.zero_polls;
    gap_en = v.tap_gap; tap_on = 1'b1;
    exp_q.push_back({12'h010, DATA_W'(v.len)});
    for (int i = 0; i < NUM_TAPS; i++)
      exp_q.push_back({ADDR_W'(32'h20 + 4 * i), tap_base + DATA_W'(i)});
    exp_q.push_back({12'h000, 32'h1});

    pulse_start(DATA_W'(v.len));
    for (int c = 0; c < 5000 && done_cnt == 0; c++) begin
      if (v.start_mid && !pulsed && dbg_state == 3'd4) begin
        pulsed = 1'b1;
        pulse_start(32'd7);
        check($sformatf("r%0d_busy_after_mid_start", idx), 64'(busy), 64'd1);
      end else begin
        tick();
      end
    end
    repeat (3) tick();
    tap_on = 1'b0;

    check($sformatf("r%0d_aw_count", idx), 64'(got_aw.size()), 64'(exp_q.size()));
    check($sformatf("r%0d_w_count", idx), 64'(got_w.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_aw.size() && i < got_w.size(); i++)
      check($sformatf("r%0d_write%0d", idx, i), 64'({got_aw[i], got_w[i]}), 64'(exp_q[i]));
    check($sformatf("r%0d_order", idx), 64'(order_viol), 64'd0);
    check($sformatf("r%0d_split_cycles", idx), 64'(split_cnt), 64'(v.exp_split));
    check($sformatf("r%0d_ss_beats", idx), 64'(ss_beats), 64'(v.len));
    check($sformatf("r%0d_tlast_count", idx), 64'(tlast_cnt), 64'd1);
    check($sformatf("r%0d_tlast_index", idx), 64'(tlast_idx), 64'(v.len - 1));
    check($sformatf("r%0d_ar_handshakes", idx), 64'(ar_hs), 64'(v.exp_ar));
    check($sformatf("r%0d_done_pulses", idx), 64'(done_cnt), 64'd1);
    check($sformatf("r%0d_done_latency", idx), 64'(done_cyc - rdone_cyc), 64'd1);
    check($sformatf("r%0d_gap_ready", idx), 64'(gap_viol), 64'd0);
    check($sformatf("r%0d_busy_end", idx), 64'(busy), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vec_t rv;
    int hs_snap;
    aw_delay = 0; w_delay = 0; zero_polls = 0; gap_en = 1'b0; tap_on = 1'b0;
    aw_age = 0; w_age = 0;
    clear_run(0);

    //              len  awd wd  zp gap mid ar split
    vecs[0] = '{600, 0,  0,  0, 0,  0,  1, 0};
    vecs[1] = '{5,   0,  1,  2, 1,  0,  3, 13};
    vecs[2] = '{1,   2,  0,  1, 0,  0,  2, 26};
    vecs[3] = '{3,   1,  1,  0, 0,  1,  1, 0};

    repeat (3) tick();
    check("reset_outputs",
          64'({busy, done, tap_ready, awvalid, awaddr, wvalid, wdata, arvalid,
               araddr, rready, stream_en, ss_tlast, dbg_state}), 64'd0);
    axis_rst_n = 1'b1;
    tick();

    // start with zero length is ignored
    pulse_start(32'd0);
    repeat (5) tick();
    check("zero_len_busy", 64'(busy), 64'd0);
    check("zero_len_writes", 64'(aw_hs + w_hs + ar_hs), 64'd0);

    for (int k = 0; k < 4; k++) run_case(vecs[k], k);

    // reset while writing tap 4 aborts the run
    clear_run(7);
    aw_delay = 0; w_delay = 0; zero_polls = 0; gap_en = 1'b0; tap_on = 1'b1;
    pulse_start(32'd8);
    for (int c = 0; c < 200 && !(tap_ptr == 5 && dbg_state == 3'd2); c++) tick();
    check("rst_reached_tap4", 64'(tap_ptr), 64'd5);
    axis_rst_n = 1'b0;
    #1;
    check("rst_mid_outputs",
          64'({busy, done, tap_ready, awvalid, awaddr, wvalid, wdata, arvalid,
               araddr, rready, stream_en, ss_tlast, dbg_state}), 64'd0);
    hs_snap = aw_hs;
    tap_on = 1'b0;
    repeat (4) tick();
    check("rst_mid_no_writes", 64'(aw_hs), 64'(hs_snap));
    check("rst_mid_no_done", 64'(done_cnt), 64'd0);
    axis_rst_n = 1'b1;
    tick();
    rv = '{4, 0, 0, 0, 0, 0, 1, 0};
    run_case(rv, 8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
